// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared types and constants for the pipeline stall/flush controller
//
// Purpose: controller state encoding and register-file constants used by
//          pipeline_ctrl and hazard_detect.
// Ports:   none (package).

package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    ERROR    = 2'd3
  } ctrl_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// rtl/pipeline_ctrl_hazard_detect.sv - combinational load-use hazard comparator
//
// Purpose: flags an instruction in ID that reads the destination of a load
//          currently in EX.
// Ports:   id_rs1/id_rs2, id_uses_rs1/id_uses_rs2 - ID source registers and use flags
//          ex_mem_read, ex_rd                    - EX instruction is a load, its rd
//          lu_hazard                             - load-use hazard present

module hazard_detect
  import pipeline_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  output logic       lu_hazard
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_match = id_uses_rs2 && (id_rs2 == ex_rd);

  // x0 is hardwired to zero, so a load into it never creates a dependency.
  assign lu_hazard = ex_mem_read && (ex_rd != REG_ZERO) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush controller for the 5-stage RISC-V pipeline
//
// Purpose: resolves memory-wait, branch-redirect and load-use conditions
//          (in that priority order) into buffer enables/flushes, detects
//          data-memory timeouts and keeps saturating stall/flush counters.
// Ports:   clk, rst_n                     - clock, async active-low reset
//          id_*, ex_mem_read, ex_rd       - load-use hazard inputs
//          mem_branch, mem_zero, mem_pc_b - EX/MEM branch outcome and target
//          mem_access, dmem_ready         - data-memory handshake
//          pc_write, pc_sel, pc_target    - PC control
//          *_write, *_flush, memwb_bubble - pipeline buffer control
//          mem_err                        - sticky memory timeout
//          stall_cnt, flush_cnt           - saturating performance counters

module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             mem_branch,
  input  logic             mem_zero,
  input  logic [63:0]      mem_pc_b,
  input  logic             mem_access,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             pc_sel,
  output logic [63:0]      pc_target,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_flush,
  output logic             exmem_write,
  output logic             exmem_flush,
  output logic             memwb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Wide enough to hold MEM_TIMEOUT itself, the value reached on entering ERROR.
  localparam int                WAIT_W       = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  ctrl_state_t       state;
  ctrl_state_t       state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;
  logic              lu_hazard;
  logic              branch_taken;
  logic              freeze;
  logic              resolve;
  logic              lu_en;
  logic              stall_inc;
  logic              flush_inc;

  hazard_detect u_hazard_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .lu_hazard   (lu_hazard)
  );

  assign branch_taken = mem_branch && mem_zero;
  assign pc_target    = mem_pc_b;

  always_comb begin
    pc_write     = 1'b1;
    pc_sel       = 1'b0;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_flush   = 1'b0;
    exmem_write  = 1'b1;
    exmem_flush  = 1'b0;
    memwb_bubble = 1'b0;
    state_nxt    = state;
    wait_nxt     = wait_cnt;
    freeze       = 1'b0;
    resolve      = 1'b0;
    lu_en        = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;

    case (state)
      ERROR: begin
        freeze = 1'b1;
      end
      MEM_WAIT: begin
        if (!dmem_ready) begin
          freeze    = 1'b1;
          stall_inc = 1'b1;
          wait_nxt  = wait_cnt + 1'b1;
          state_nxt = (wait_cnt == TIMEOUT_LAST) ? ERROR : MEM_WAIT;
        end else begin
          // Access completes: this cycle behaves exactly like RUN.
          wait_nxt = '0;
          resolve  = 1'b1;
          lu_en    = 1'b1;
        end
      end
      default: begin
        if (mem_access && !dmem_ready) begin
          freeze    = 1'b1;
          stall_inc = 1'b1;
          wait_nxt  = WAIT_W'(1);
          state_nxt = MEM_WAIT;
        end else begin
          resolve = 1'b1;
          // Masked in LU_STALL so one load-use produces exactly one bubble.
          lu_en   = (state == RUN);
        end
      end
    endcase

    if (freeze) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      memwb_bubble = 1'b1;
    end

    if (resolve) begin
      state_nxt = RUN;
      if (branch_taken) begin
        // The ID instruction is squashed, so a coincident load-use is moot.
        pc_sel      = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        flush_inc   = 1'b1;
      end else if (lu_en && lu_hazard) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
        stall_inc  = 1'b1;
        state_nxt  = LU_STALL;
      end
    end

    // Hold every buffer and inject bubbles while reset is asserted.
    if (!rst_n) begin
      pc_write     = 1'b0;
      pc_sel       = 1'b0;
      ifid_write   = 1'b0;
      ifid_flush   = 1'b1;
      idex_write   = 1'b0;
      idex_flush   = 1'b1;
      exmem_write  = 1'b0;
      exmem_flush  = 1'b1;
      memwb_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (state_nxt == ERROR) begin
        mem_err <= 1'b1;
      end
      if (stall_inc && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (flush_inc && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl

module tb_pipeline_ctrl;

  localparam int CNT_W = 4;

  // {pc_write, pc_sel, ifid_write, ifid_flush, idex_write, idex_flush,
  //  exmem_write, exmem_flush, memwb_bubble}
  localparam logic [8:0] C_DEF = 9'b1_0_1_0_1_0_1_0_0;
  localparam logic [8:0] C_RST = 9'b0_0_0_1_0_1_0_1_1;
  localparam logic [8:0] C_LU  = 9'b0_0_0_0_1_1_1_0_0;
  localparam logic [8:0] C_BR  = 9'b1_1_1_1_1_1_1_1_0;
  localparam logic [8:0] C_FRZ = 9'b0_0_0_0_0_0_0_0_1;

  logic             clk;
  logic             rst_n;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic             ex_mem_read;
  logic [4:0]       ex_rd;
  logic             mem_branch;
  logic             mem_zero;
  logic [63:0]      mem_pc_b;
  logic             mem_access;
  logic             dmem_ready;
  logic             pc_write;
  logic             pc_sel;
  logic [63:0]      pc_target;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_write;
  logic             idex_flush;
  logic             exmem_write;
  logic             exmem_flush;
  logic             memwb_bubble;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [8:0]       ctrl;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_stall;
  int exp_flush;

  pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_uses_rs1  (id_uses_rs1),
    .id_uses_rs2  (id_uses_rs2),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .mem_branch   (mem_branch),
    .mem_zero     (mem_zero),
    .mem_pc_b     (mem_pc_b),
    .mem_access   (mem_access),
    .dmem_ready   (dmem_ready),
    .pc_write     (pc_write),
    .pc_sel       (pc_sel),
    .pc_target    (pc_target),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_write   (idex_write),
    .idex_flush   (idex_flush),
    .exmem_write  (exmem_write),
    .exmem_flush  (exmem_flush),
    .memwb_bubble (memwb_bubble),
    .mem_err      (mem_err),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  assign ctrl = {pc_write, pc_sel, ifid_write, ifid_flush, idex_write, idex_flush,
                 exmem_write, exmem_flush, memwb_bubble};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1      = 5'd1;
    id_rs2      = 5'd2;
    id_uses_rs1 = 1'b0;
    id_uses_rs2 = 1'b0;
    ex_mem_read = 1'b0;
    ex_rd       = 5'd0;
    mem_branch  = 1'b0;
    mem_zero    = 1'b0;
    mem_access  = 1'b0;
    dmem_ready  = 1'b1;
  endtask

  task automatic set_lu();
    ex_mem_read = 1'b1;
    ex_rd       = 5'd5;
    id_uses_rs1 = 1'b1;
    id_rs1      = 5'd5;
  endtask

  task automatic counters(input string tag);
    check_eq({tag, "_stall"}, 64'(stall_cnt), 64'(exp_stall));
    check_eq({tag, "_flush"}, 64'(flush_cnt), 64'(exp_flush));
  endtask

  initial begin
    exp_stall = 0;
    exp_flush = 0;
    idle();
    mem_pc_b = 64'h1234;
    rst_n    = 1'b0;
    #3;
    check_eq("rst_ctrl", ctrl, C_RST);
    check_eq("rst_err", mem_err, 1'b0);
    check_eq("rst_target", pc_target, 64'h1234);
    counters("rst");
    step();
    step();
    rst_n = 1'b1;
    #1;
    check_eq("run_ctrl", ctrl, C_DEF);

    // Load-use on rs1, then one masked LU_STALL cycle with the hazard still present
    set_lu();
    #1 check_eq("lu_rs1", ctrl, C_LU);
    step(); exp_stall++;
    #1 check_eq("lu_masked", ctrl, C_DEF);
    counters("lu");
    step();
    idle();

    // No hazard: load into x0, or rs1 not used
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_uses_rs1 = 1'b1; id_rs1 = 5'd0;
    #1 check_eq("lu_x0", ctrl, C_DEF);
    step();
    ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b0;
    #1 check_eq("lu_nouse", ctrl, C_DEF);
    step();
    counters("nolu");
    // Hazard via rs2
    id_uses_rs2 = 1'b1; id_rs2 = 5'd5;
    #1 check_eq("lu_rs2", ctrl, C_LU);
    step(); exp_stall++;
    idle();
    step();

    // Branch taken with a coincident load-use: redirect wins, no stall
    set_lu();
    mem_branch = 1'b1; mem_zero = 1'b1; mem_pc_b = 64'h80;
    #1 check_eq("br_ctrl", ctrl, C_BR);
    check_eq("br_target", pc_target, 64'h80);
    step(); exp_flush++;
    counters("br");
    idle();
    mem_branch = 1'b1;
    #1 check_eq("br_not_taken", ctrl, C_DEF);
    step();

    // Memory wait of 3 cycles then ready
    idle();
    mem_access = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check_eq("mw_freeze", ctrl, C_FRZ);
      step(); exp_stall++;
    end
    dmem_ready = 1'b1;
    #1 check_eq("mw_done", ctrl, C_DEF);
    step();
    counters("mw");

    // Branch taken on the cycle dmem_ready rises, then back in RUN
    dmem_ready = 1'b0;
    step(); exp_stall++;
    dmem_ready = 1'b1; mem_branch = 1'b1; mem_zero = 1'b1; mem_pc_b = 64'h200;
    #1 check_eq("mw_br_ctrl", ctrl, C_BR);
    check_eq("mw_br_target", pc_target, 64'h200);
    step(); exp_flush++;
    idle();
    #1 check_eq("mw_br_run", ctrl, C_DEF);
    counters("mwbr");

    // Load-use evaluated when leaving MEM_WAIT
    mem_access = 1'b1; dmem_ready = 1'b0;
    step(); exp_stall++;
    dmem_ready = 1'b1; set_lu();
    #1 check_eq("mw_lu", ctrl, C_LU);
    step(); exp_stall++;
    #1 check_eq("mw_lu_masked", ctrl, C_DEF);
    step();
    idle();

    // Memory wait beginning in LU_STALL
    set_lu();
    #1 check_eq("lus_lu", ctrl, C_LU);
    step(); exp_stall++;
    idle();
    mem_access = 1'b1; dmem_ready = 1'b0;
    #1 check_eq("lus_mw", ctrl, C_FRZ);
    step(); exp_stall++;
    dmem_ready = 1'b1;
    #1 check_eq("lus_mw_done", ctrl, C_DEF);
    step();
    counters("lus");

    // Timeout: 4 frozen cycles, then ERROR holds regardless of ready
    mem_access = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 check_eq("to_freeze", ctrl, C_FRZ);
      check_eq("to_err_pre", mem_err, 1'b0);
      step(); exp_stall++;
    end
    check_eq("to_err", mem_err, 1'b1);
    counters("to");
    dmem_ready = 1'b1; mem_branch = 1'b1; mem_zero = 1'b1;
    #1 check_eq("err_freeze", ctrl, C_FRZ);
    step();
    step();
    check_eq("err_hold", mem_err, 1'b1);
    counters("err");

    // Reset pulse out of ERROR
    idle();
    rst_n = 1'b0;
    #1 check_eq("err_rst_ctrl", ctrl, C_RST);
    step();
    rst_n = 1'b1;
    exp_stall = 0; exp_flush = 0;
    #1 check_eq("err_rst_err", mem_err, 1'b0);
    check_eq("err_rst_run", ctrl, C_DEF);
    counters("err_rst");

    // Reset in the middle of MEM_WAIT returns to RUN
    mem_access = 1'b1; dmem_ready = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    idle();
    #1 check_eq("mw_rst_run", ctrl, C_DEF);
    counters("mw_rst");
    step();

    // Saturation: 20 load-use stalls and 20 redirects into 4-bit counters
    for (int i = 0; i < 20; i++) begin
      set_lu();
      step();
      idle();
      step();
    end
    check_eq("sat_stall", stall_cnt, 4'hf);
    mem_branch = 1'b1; mem_zero = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check_eq("sat_flush", flush_cnt, 4'hf);
    check_eq("sat_stall_hold", stall_cnt, 4'hf);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
